// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
//   REGFILE_XLEN / REGFILE_ADDR_SIZE / REGFILE_NUM_REGS : default geometry
//   rf_state_t : clear-sweep controller state
package regfile_pkg;

    localparam int REGFILE_XLEN      = 32;
    localparam int REGFILE_ADDR_SIZE = 5;
    localparam int REGFILE_NUM_REGS  = 32;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep controller for the register file.
// After reset, it walks clear_ptr from 1 up to NUM_REGISTERS-1 and zeroes
// one register per cycle. x0 is never stored, so the sweep starts at 1.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   init_busy    : registered, high while the sweep runs (and while rst held)
//   clear_we     : write strobe into the array for the sweep
//   clear_addr   : register being cleared this cycle
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_SIZE     = REGFILE_ADDR_SIZE,
    parameter int NUM_REGISTERS = REGFILE_NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_busy,
    output logic                 clear_we,
    output logic [ADDR_SIZE-1:0] clear_addr
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR  = ADDR_SIZE'(NUM_REGISTERS - 1);
    localparam logic [ADDR_SIZE-1:0] FIRST_ADDR = ADDR_SIZE'(1);

    rf_state_t            state;
    logic [ADDR_SIZE-1:0] clear_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RF_CLEAR;
            clear_ptr <= FIRST_ADDR;
            init_busy <= 1'b1;
        end else begin
            case (state)
                RF_CLEAR: begin
                    // The cycle that clears the last register is also the
                    // last busy cycle.
                    if (clear_ptr == LAST_ADDR) begin
                        state     <= RF_READY;
                        init_busy <= 1'b0;
                    end else begin
                        clear_ptr <= clear_ptr + 1'b1;
                    end
                end
                default: begin
                    state     <= RF_READY;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clear_we   = (state == RF_CLEAR);
    assign clear_addr = clear_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: one write port, NUM_READ_PORTS
// registered read ports (1-cycle latency), hardwired-zero x0.
// Contents are cleared by a sequential sweep after reset (init_busy high).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   init_busy     : sweep in progress, reads and writes ignored
//   write_enable/write_addr/write_data : writeback port
//   read_enable   : per-port read request
//   read_addr     : packed, port i at [i*ADDR_SIZE +: ADDR_SIZE]
//   read_data     : packed, port i at [i*XLEN +: XLEN]; 0 when idle
//   read_valid    : per-port, one cycle after an accepted request
// Build option: REGFILE_BYPASS_EN selects write-first behaviour for a read
// and write to the same register in one cycle (default is read-first).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_SIZE      = REGFILE_ADDR_SIZE,
    parameter int XLEN           = REGFILE_XLEN,
    parameter int NUM_REGISTERS  = REGFILE_NUM_REGS,
    parameter int NUM_READ_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                init_busy,
    input  logic                                write_enable,
    input  logic [ADDR_SIZE-1:0]                write_addr,
    input  logic [XLEN-1:0]                     write_data,
    input  logic [NUM_READ_PORTS-1:0]           read_enable,
    input  logic [NUM_READ_PORTS*ADDR_SIZE-1:0] read_addr,
    output logic [NUM_READ_PORTS*XLEN-1:0]      read_data,
    output logic [NUM_READ_PORTS-1:0]           read_valid
);

    localparam int                 IDX_W    = $clog2(NUM_REGISTERS);
    localparam logic [ADDR_SIZE:0] NUM_REGS = (ADDR_SIZE + 1)'(NUM_REGISTERS);

    logic                 clear_we;
    logic [ADDR_SIZE-1:0] clear_addr;
    logic                 wr_ok;
    logic [XLEN-1:0]      mem [NUM_REGISTERS];

    // x0 and out-of-range registers are never stored or read from the array.
    function automatic logic addr_ok(input logic [ADDR_SIZE-1:0] a);
        return (a != '0) && ({1'b0, a} < NUM_REGS);
    endfunction

    regfile_clear_ctrl #(
        .ADDR_SIZE     (ADDR_SIZE),
        .NUM_REGISTERS (NUM_REGISTERS)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .init_busy  (init_busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    assign wr_ok = write_enable && !init_busy && !rst && addr_ok(write_addr);

    // Array is deliberately not reset; the sweep owns the write port while busy.
    always_ff @(posedge clk) begin
        if (clear_we)
            mem[clear_addr[IDX_W-1:0]] <= '0;
        else if (wr_ok)
            mem[write_addr[IDX_W-1:0]] <= write_data;
    end

    for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
        logic [ADDR_SIZE-1:0] ra;
        logic [XLEN-1:0]      rd_next;
        logic [XLEN-1:0]      rd_q;
        logic                 vld_q;

        assign ra = read_addr[i*ADDR_SIZE +: ADDR_SIZE];

        always_comb begin
            rd_next = '0;
            if (addr_ok(ra)) begin
                rd_next = mem[ra[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (write_addr == ra))
                    rd_next = write_data;
`endif
            end
        end

        // Idle ports return 0 rather than holding, so stale data is obvious.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else if (read_enable[i] && !init_busy) begin
                rd_q  <= rd_next;
                vld_q <= 1'b1;
            end else begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end
        end

        assign read_data[i*XLEN +: XLEN] = rd_q;
        assign read_valid[i]             = vld_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        init_busy;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [1:0]  read_enable;
    logic [9:0]  read_addr;
    logic [63:0] read_data;
    logic [1:0]  read_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .ADDR_SIZE(5), .XLEN(32), .NUM_REGISTERS(32), .NUM_READ_PORTS(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_busy    (init_busy),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .read_valid   (read_valid)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  ev;
        logic [31:0] ed0;
        logic [31:0] ed1;
    } vec_t;

    vec_t tv [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        read_enable  = '0;
        read_addr    = '0;
    endtask

    // Counts cycles init_busy stays high from now on; flags any read_valid.
    task automatic measure_sweep(output int cnt, output bit saw_valid);
        cnt = 0;
        saw_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (read_valid != 2'b00 || read_data != 64'h0) saw_valid = 1'b1;
            if (!init_busy) break;
            cnt++;
            tick();
        end
    endtask

    initial begin
        int  cnt;
        bit  saw;
        bit  all_zero;
        bit  all_valid;

        idle();
        rst = 1'b1;
        tick();

        // Reset state
        check("reset_busy",  {63'h0, init_busy}, 64'h1);
        check("reset_valid", {62'h0, read_valid}, 64'h0);
        check("reset_data",  read_data, 64'h0);

        // Test 1: single-cycle reset pulse, reads/writes attempted during sweep
        rst = 1'b0;
        write_enable = 1'b1; write_addr = 5'd3; write_data = 32'h77;
        read_enable = 2'b11; read_addr = {5'd3, 5'd3};
        measure_sweep(cnt, saw);
        idle();
        check("sweep_len", 64'(cnt), 64'd31);
        check("sweep_no_read", {63'h0, saw}, 64'h0);

        all_zero = 1'b1; all_valid = 1'b1;
        for (int a = 0; a < 32; a++) begin
            read_enable = 2'b11;
            read_addr   = {5'(a), 5'(a)};
            tick();
            if (read_valid != 2'b11) all_valid = 1'b0;
            if (read_data != 64'h0) all_zero = 1'b0;
        end
        idle();
        check("post_sweep_valid", {63'h0, all_valid}, 64'h1);
        check("post_sweep_zero",  {63'h0, all_zero},  64'h1);
        tick();

        // Table: tests 2, 3, 4, 6 plus port-distinct and x0 corner cases
        tv[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0, 32'h0};
        tv[1]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5,  2'b11, 32'hDEADBEEF, 32'hDEADBEEF};
        tv[2]  = '{1'b1, 5'd0,  32'h12345678, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0, 32'h0};
        tv[3]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd0,  5'd0,  2'b01, 32'h0, 32'h0};
        tv[4]  = '{1'b1, 5'd7,  32'h1,        2'b00, 5'd0,  5'd0,  2'b00, 32'h0, 32'h0};
        tv[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 2'b01, 5'd7,  5'd0,  2'b01,
                   BYP ? 32'hA5A5A5A5 : 32'h1, 32'h0};
        tv[6]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd7,  5'd0,  2'b01, 32'hA5A5A5A5, 32'h0};
        tv[7]  = '{1'b1, 5'd31, 32'hCAFEF00D, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0, 32'h0};
        tv[8]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd31, 5'd5,  2'b11, 32'hCAFEF00D, 32'hDEADBEEF};
        tv[9]  = '{1'b1, 5'd4,  32'h44,       2'b00, 5'd0,  5'd0,  2'b00, 32'h0, 32'h0};
        tv[10] = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd0,  5'd4,  2'b10, 32'h0, 32'h44};
        tv[11] = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd4,  2'b00, 32'h0, 32'h0};
        tv[12] = '{1'b1, 5'd5,  32'h11111111, 2'b11, 5'd0,  5'd5,  2'b11,
                   32'h0, BYP ? 32'h11111111 : 32'hDEADBEEF};
        tv[13] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5,  2'b11, 32'h11111111, 32'h11111111};
        tv[14] = '{1'b1, 5'd0,  32'h9999,     2'b01, 5'd0,  5'd0,  2'b01, 32'h0, 32'h0};

        for (int i = 0; i < 15; i++) begin
            write_enable = tv[i].we;
            write_addr   = tv[i].wa;
            write_data   = tv[i].wd;
            read_enable  = tv[i].re;
            read_addr    = {tv[i].ra1, tv[i].ra0};
            tick();
            check($sformatf("vec%0d_valid", i), {62'h0, read_valid}, {62'h0, tv[i].ev});
            check($sformatf("vec%0d_data0", i), {32'h0, read_data[31:0]},  {32'h0, tv[i].ed0});
            check($sformatf("vec%0d_data1", i), {32'h0, read_data[63:32]}, {32'h0, tv[i].ed1});
        end
        idle();
        tick();

        // Test 5: reset mid-sweep restarts it; writes during CLEAR are dropped
        write_enable = 1'b1; write_addr = 5'd3; write_data = 32'h55;
        tick();
        idle();
        read_enable = 2'b01; read_addr = {5'd0, 5'd3};
        tick();
        idle();
        check("x3_before_reset", {32'h0, read_data[31:0]}, 64'h55);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("mid_sweep_busy", {63'h0, init_busy}, 64'h1);
        rst = 1'b1;
        write_enable = 1'b1; write_addr = 5'd3; write_data = 32'h77;
        tick();
        rst = 1'b0;
        read_enable = 2'b01; read_addr = {5'd0, 5'd3};
        measure_sweep(cnt, saw);
        idle();
        check("resweep_len", 64'(cnt), 64'd31);
        check("resweep_no_read", {63'h0, saw}, 64'h0);

        read_enable = 2'b11; read_addr = {5'd5, 5'd3};
        tick();
        idle();
        check("x3_after_resweep_valid", {62'h0, read_valid}, 64'h3);
        check("x3_after_resweep", read_data, 64'h0);

        // Test 6: single-cycle valid pulse on port1, port0 idle throughout
        write_enable = 1'b1; write_addr = 5'd4; write_data = 32'h4444;
        tick();
        idle();
        read_enable = 2'b10; read_addr = {5'd4, 5'd4};
        tick();
        check("p1_pulse_valid", {62'h0, read_valid}, 64'h2);
        check("p1_pulse_data",  read_data, {32'h4444, 32'h0});
        read_enable = 2'b00;
        tick();
        check("p1_drop_valid", {62'h0, read_valid}, 64'h0);
        check("p1_drop_data",  read_data, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
